// File: rtl/unidade_controle_mc_if.sv
// Datapath <-> control unit bundle for the multi-cycle MIPS-style core.
// master = control unit (producer of ALU/memory controls), slave = datapath.
interface unidade_controle_mc_if;
   logic [5:0] instrucao_op;
   logic       zero;
   logic       mem_ready;
   logic [3:0] alu_op;
   logic       alu_src_b;
   logic       mem_read;
   logic       mem_write;
   logic       iord;
   logic       ir_write;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       reg_write;
   logic       mem_to_reg;
   logic       resto_write;
   logic       erro_op;
   logic       halted;
   logic [2:0] estado;

   modport master (
      input  instrucao_op, zero, mem_ready,
      output alu_op, alu_src_b, mem_read, mem_write, iord,
      output ir_write, pc_write, pc_src, reg_write, mem_to_reg,
      output resto_write, erro_op, halted, estado
   );

   modport slave (
      output instrucao_op, zero, mem_ready,
      input  alu_op, alu_src_b, mem_read, mem_write, iord,
      input  ir_write, pc_write, pc_src, reg_write, mem_to_reg,
      input  resto_write, erro_op, halted, estado
   );
endinterface

// File: rtl/unidade_controle_mc.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb with MUL/DIV hold.
// Optional UNIDADE_CONTROLE_PASSO_EN adds a passo input for single-stepping.
module unidade_controle_mc #(
   parameter int MUL_CYCLES = 1,
   parameter int DIV_CYCLES = 1
) (
   input  logic clock,
   input  logic reset,
`ifdef UNIDADE_CONTROLE_PASSO_EN
   input  logic passo,
`endif
   unidade_controle_mc_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } estado_t;

   localparam logic [5:0] OP_NOP  = 6'b000000;
   localparam logic [5:0] OP_ADD  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_SUB  = 6'b000011;
   localparam logic [5:0] OP_SUBI = 6'b000100;
   localparam logic [5:0] OP_MUL  = 6'b000101;
   localparam logic [5:0] OP_DIV  = 6'b000110;
   localparam logic [5:0] OP_NOT  = 6'b000111;
   localparam logic [5:0] OP_AND  = 6'b001000;
   localparam logic [5:0] OP_OR   = 6'b001001;
   localparam logic [5:0] OP_XOR  = 6'b001010;
   localparam logic [5:0] OP_SLT  = 6'b001011;
   localparam logic [5:0] OP_SGT  = 6'b001100;
   localparam logic [5:0] OP_SR   = 6'b001101;
   localparam logic [5:0] OP_SL   = 6'b001110;
   localparam logic [5:0] OP_BEQ  = 6'b001111;
   localparam logic [5:0] OP_BNEQ = 6'b010000;
   localparam logic [5:0] OP_LW   = 6'b010001;
   localparam logic [5:0] OP_SW   = 6'b010010;
   localparam logic [5:0] OP_J    = 6'b010011;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [7:0] MUL_LAST = 8'(MUL_CYCLES - 1);
   localparam logic [7:0] DIV_LAST = 8'(DIV_CYCLES - 1);

   estado_t    r_estado;
   estado_t    w_estado_next;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_next;
   logic       w_req;

   logic [5:0] w_op;
   logic [3:0] w_op_alu;
   logic       w_legal;
   logic       w_imm;
   logic       w_is_mem;
   logic       w_is_br;

   logic [3:0] w_alu_op;
   logic       w_alu_src_b;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_iord;
   logic       w_ir_write;
   logic       w_pc_write;
   logic [1:0] w_pc_src;
   logic       w_reg_write;
   logic       w_mem_to_reg;
   logic       w_resto_write;
   logic       w_erro_op;
   logic       w_halted;

   assign w_op = bus.instrucao_op;

`ifdef UNIDADE_CONTROLE_PASSO_EN
   logic r_passo_ok;

   // Arm the fetch request once passo is sampled; disarm on leaving FETCH.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_passo_ok <= 1'b0;
      end else if (r_estado != S_FETCH || w_estado_next != S_FETCH) begin
         r_passo_ok <= 1'b0;
      end else if (passo) begin
         r_passo_ok <= 1'b1;
      end
   end

   assign w_req = r_passo_ok;
`else
   assign w_req = 1'b1;
`endif

   // Opcode decode: ALU code, legality and instruction class.
   always_comb begin
      w_op_alu = 4'b0000;
      w_legal  = 1'b1;
      w_imm    = 1'b0;
      w_is_mem = 1'b0;
      w_is_br  = 1'b0;
      case (w_op)
         OP_NOP:  w_op_alu = 4'b0000;
         OP_ADD:  w_op_alu = 4'b0000;
         OP_ADDI: begin w_op_alu = 4'b0000; w_imm = 1'b1; end
         OP_SUB:  w_op_alu = 4'b0001;
         OP_SUBI: begin w_op_alu = 4'b0001; w_imm = 1'b1; end
         OP_MUL:  w_op_alu = 4'b0010;
         OP_DIV:  w_op_alu = 4'b0011;
         OP_NOT:  w_op_alu = 4'b0100;
         OP_AND:  w_op_alu = 4'b0101;
         OP_OR:   w_op_alu = 4'b0110;
         OP_XOR:  w_op_alu = 4'b0111;
         OP_SLT:  w_op_alu = 4'b1000;
         OP_SGT:  w_op_alu = 4'b1001;
         OP_SR:   w_op_alu = 4'b1100;
         OP_SL:   w_op_alu = 4'b1101;
         OP_BEQ:  begin w_op_alu = 4'b1010; w_is_br = 1'b1; end
         OP_BNEQ: begin w_op_alu = 4'b1011; w_is_br = 1'b1; end
         OP_LW:   begin w_imm = 1'b1; w_is_mem = 1'b1; end
         OP_SW:   begin w_imm = 1'b1; w_is_mem = 1'b1; end
         OP_J:    w_op_alu = 4'b0000;
         OP_HALT: w_op_alu = 4'b0000;
         default: w_legal = 1'b0;
      endcase
   end

   // State and EXEC cycle counter registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado <= S_FETCH;
         r_cnt    <= 8'd0;
      end else begin
         r_estado <= w_estado_next;
         r_cnt    <= w_cnt_next;
      end
   end

   // Next state and control outputs; everything forced low during reset.
   always_comb begin
      w_estado_next = r_estado;
      w_cnt_next    = r_cnt;
      w_alu_op      = 4'b0000;
      w_alu_src_b   = 1'b0;
      w_mem_read    = 1'b0;
      w_mem_write   = 1'b0;
      w_iord        = 1'b0;
      w_ir_write    = 1'b0;
      w_pc_write    = 1'b0;
      w_pc_src      = 2'b00;
      w_reg_write   = 1'b0;
      w_mem_to_reg  = 1'b0;
      w_resto_write = 1'b0;
      w_erro_op     = 1'b0;
      w_halted      = 1'b0;
      case (r_estado)
         S_FETCH: begin
            w_mem_read = w_req;
            if (w_req && bus.mem_ready) begin
               w_ir_write    = 1'b1;
               w_pc_write    = 1'b1;
               w_estado_next = S_DECODE;
            end
         end
         S_DECODE: begin
            if (w_op == OP_HALT) begin
               w_estado_next = S_HALT;
            end else if (w_op == OP_NOP) begin
               w_estado_next = S_FETCH;
            end else if (!w_legal) begin
               w_erro_op     = 1'b1;
               w_estado_next = S_FETCH;
            end else begin
               w_cnt_next    = 8'd0;
               w_estado_next = S_EXEC;
            end
         end
         S_EXEC: begin
            w_alu_op    = w_op_alu;
            w_alu_src_b = w_imm;
            if (w_op == OP_MUL) begin
               if (r_cnt == MUL_LAST) w_estado_next = S_WB;
               else w_cnt_next = r_cnt + 8'd1;
            end else if (w_op == OP_DIV) begin
               if (r_cnt == DIV_LAST) w_estado_next = S_WB;
               else w_cnt_next = r_cnt + 8'd1;
            end else if (w_is_br) begin
               w_pc_src      = 2'b01;
               w_pc_write    = bus.zero;
               w_estado_next = S_FETCH;
            end else if (w_op == OP_J) begin
               w_pc_src      = 2'b10;
               w_pc_write    = 1'b1;
               w_estado_next = S_FETCH;
            end else if (w_is_mem) begin
               w_estado_next = S_MEM;
            end else begin
               w_estado_next = S_WB;
            end
         end
         S_MEM: begin
            w_iord      = 1'b1;
            w_alu_src_b = 1'b1;
            if (w_op == OP_LW) begin
               w_mem_read = 1'b1;
               if (bus.mem_ready) w_estado_next = S_WB;
            end else begin
               w_mem_write = 1'b1;
               if (bus.mem_ready) w_estado_next = S_FETCH;
            end
         end
         S_WB: begin
            w_alu_op      = w_op_alu;
            w_reg_write   = 1'b1;
            w_mem_to_reg  = (w_op == OP_LW);
            w_resto_write = (w_op == OP_DIV);
            w_estado_next = S_FETCH;
         end
         S_HALT: begin
            w_halted = 1'b1;
         end
         default: begin
            w_estado_next = S_FETCH;
         end
      endcase
      if (reset) begin
         w_alu_op      = 4'b0000;
         w_alu_src_b   = 1'b0;
         w_mem_read    = 1'b0;
         w_mem_write   = 1'b0;
         w_iord        = 1'b0;
         w_ir_write    = 1'b0;
         w_pc_write    = 1'b0;
         w_pc_src      = 2'b00;
         w_reg_write   = 1'b0;
         w_mem_to_reg  = 1'b0;
         w_resto_write = 1'b0;
         w_erro_op     = 1'b0;
         w_halted      = 1'b0;
      end
   end

   assign bus.alu_op      = w_alu_op;
   assign bus.alu_src_b   = w_alu_src_b;
   assign bus.mem_read    = w_mem_read;
   assign bus.mem_write   = w_mem_write;
   assign bus.iord        = w_iord;
   assign bus.ir_write    = w_ir_write;
   assign bus.pc_write    = w_pc_write;
   assign bus.pc_src      = w_pc_src;
   assign bus.reg_write   = w_reg_write;
   assign bus.mem_to_reg  = w_mem_to_reg;
   assign bus.resto_write = w_resto_write;
   assign bus.erro_op     = w_erro_op;
   assign bus.halted      = w_halted;
   assign bus.estado      = reset ? 3'd0 : r_estado;

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Directed bench for unidade_controle_mc (DIV_CYCLES = 4, MUL_CYCLES = 1).
// Expected values are hand-derived from the state/opcode tables.
module tb_unidade_controle_mc;

   logic clock;
   logic reset;
   int   checks;
   int   failures;

   unidade_controle_mc_if bus ();

   unidade_controle_mc #(
      .MUL_CYCLES(1),
      .DIV_CYCLES(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nx();
      @(posedge clock);
      #1;
   endtask

   // FETCH (mem_ready=1) then DECODE with the given opcode; ends in cycle after DECODE.
   task automatic fetch_decode(input logic [5:0] op);
      bus.instrucao_op = op;
      bus.mem_ready    = 1'b1;
      #1;
      chk("fd_fetch_estado", 8'(bus.estado), 8'd0);
      nx();
      #1;
      chk("fd_decode_estado", 8'(bus.estado), 8'd1);
      nx();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus.instrucao_op = 6'b000000;
      bus.zero         = 1'b0;
      bus.mem_ready    = 1'b0;
      nx();
      nx();
      chk("rst_mem_read", 8'(bus.mem_read), 8'd0);
      chk("rst_estado", 8'(bus.estado), 8'd0);
      chk("rst_alu_op", 8'(bus.alu_op), 8'd0);
      chk("rst_ir_write", 8'(bus.ir_write), 8'd0);
      reset = 1'b0;
      #1;
      chk("fetch_wait_mem_read", 8'(bus.mem_read), 8'd1);
      chk("fetch_wait_ir_write", 8'(bus.ir_write), 8'd0);
      nx();
      chk("fetch_wait_hold", 8'(bus.estado), 8'd0);

      // ADD
      bus.instrucao_op = 6'b000001;
      bus.mem_ready    = 1'b1;
      #1;
      chk("add_f_ir_write", 8'(bus.ir_write), 8'd1);
      chk("add_f_pc_write", 8'(bus.pc_write), 8'd1);
      chk("add_f_pc_src", 8'(bus.pc_src), 8'd0);
      chk("add_f_iord", 8'(bus.iord), 8'd0);
      nx();
      chk("add_d_estado", 8'(bus.estado), 8'd1);
      chk("add_d_erro", 8'(bus.erro_op), 8'd0);
      nx();
      bus.zero = 1'b1;
      #1;
      chk("add_e_estado", 8'(bus.estado), 8'd2);
      chk("add_e_alu_op", 8'(bus.alu_op), 8'd0);
      chk("add_e_src_b", 8'(bus.alu_src_b), 8'd0);
      chk("add_e_pc_write", 8'(bus.pc_write), 8'd0);
      nx();
      bus.zero = 1'b0;
      chk("add_w_estado", 8'(bus.estado), 8'd4);
      chk("add_w_reg_write", 8'(bus.reg_write), 8'd1);
      chk("add_w_mem_to_reg", 8'(bus.mem_to_reg), 8'd0);
      chk("add_w_resto", 8'(bus.resto_write), 8'd0);
      nx();
      chk("add_back_fetch", 8'(bus.estado), 8'd0);

      // DIV, 4 EXEC cycles
      fetch_decode(6'b000110);
      for (int i = 0; i < 4; i++) begin
         chk("div_e_estado", 8'(bus.estado), 8'd2);
         chk("div_e_alu_op", 8'(bus.alu_op), 8'd3);
         nx();
      end
      chk("div_w_estado", 8'(bus.estado), 8'd4);
      chk("div_w_reg_write", 8'(bus.reg_write), 8'd1);
      chk("div_w_resto", 8'(bus.resto_write), 8'd1);
      chk("div_w_alu_op", 8'(bus.alu_op), 8'd3);
      nx();
      chk("div_back_fetch", 8'(bus.estado), 8'd0);

      // MUL, single EXEC cycle
      fetch_decode(6'b000101);
      chk("mul_e_alu_op", 8'(bus.alu_op), 8'd2);
      nx();
      chk("mul_w_estado", 8'(bus.estado), 8'd4);
      chk("mul_w_resto", 8'(bus.resto_write), 8'd0);
      nx();

      // BEQ taken
      fetch_decode(6'b001111);
      bus.zero = 1'b1;
      #1;
      chk("beq1_pc_write", 8'(bus.pc_write), 8'd1);
      chk("beq1_pc_src", 8'(bus.pc_src), 8'd1);
      chk("beq1_alu_op", 8'(bus.alu_op), 8'hA);
      nx();
      chk("beq1_next", 8'(bus.estado), 8'd0);

      // BEQ not taken
      fetch_decode(6'b001111);
      bus.zero = 1'b0;
      #1;
      chk("beq0_pc_write", 8'(bus.pc_write), 8'd0);
      chk("beq0_pc_src", 8'(bus.pc_src), 8'd1);
      nx();
      chk("beq0_next", 8'(bus.estado), 8'd0);

      // BNEQ
      fetch_decode(6'b010000);
      chk("bneq_alu_op", 8'(bus.alu_op), 8'hB);
      nx();

      // J
      fetch_decode(6'b010011);
      chk("j_pc_write", 8'(bus.pc_write), 8'd1);
      chk("j_pc_src", 8'(bus.pc_src), 8'd2);
      nx();
      chk("j_next", 8'(bus.estado), 8'd0);

      // SUBI: immediate operand
      fetch_decode(6'b000100);
      chk("subi_alu_op", 8'(bus.alu_op), 8'd1);
      chk("subi_src_b", 8'(bus.alu_src_b), 8'd1);
      nx();
      nx();

      // LW with 3 wait cycles
      fetch_decode(6'b010001);
      chk("lw_e_src_b", 8'(bus.alu_src_b), 8'd1);
      bus.mem_ready = 1'b0;
      nx();
      for (int i = 0; i < 3; i++) begin
         chk("lw_m_estado", 8'(bus.estado), 8'd3);
         chk("lw_m_mem_read", 8'(bus.mem_read), 8'd1);
         chk("lw_m_iord", 8'(bus.iord), 8'd1);
         nx();
      end
      bus.mem_ready = 1'b1;
      #1;
      chk("lw_m4_mem_read", 8'(bus.mem_read), 8'd1);
      chk("lw_m4_iord", 8'(bus.iord), 8'd1);
      chk("lw_m4_alu_op", 8'(bus.alu_op), 8'd0);
      nx();
      chk("lw_w_estado", 8'(bus.estado), 8'd4);
      chk("lw_w_reg_write", 8'(bus.reg_write), 8'd1);
      chk("lw_w_mem_to_reg", 8'(bus.mem_to_reg), 8'd1);
      nx();

      // LW interrupted by reset in second MEM cycle
      fetch_decode(6'b010001);
      bus.mem_ready = 1'b0;
      nx();
      chk("lwr_m1_mem_read", 8'(bus.mem_read), 8'd1);
      nx();
      chk("lwr_m2_mem_read", 8'(bus.mem_read), 8'd1);
      reset = 1'b1;
      #1;
      chk("lwr_rst_mem_read", 8'(bus.mem_read), 8'd0);
      chk("lwr_rst_iord", 8'(bus.iord), 8'd0);
      chk("lwr_rst_estado", 8'(bus.estado), 8'd0);
      nx();
      reset = 1'b0;
      #1;
      chk("lwr_after_estado", 8'(bus.estado), 8'd0);

      // SW
      fetch_decode(6'b010010);
      nx();
      chk("sw_m_mem_write", 8'(bus.mem_write), 8'd1);
      chk("sw_m_mem_read", 8'(bus.mem_read), 8'd0);
      nx();
      chk("sw_next", 8'(bus.estado), 8'd0);

      // Illegal opcode
      bus.instrucao_op = 6'b100000;
      bus.mem_ready    = 1'b1;
      nx();
      chk("ill_d_erro", 8'(bus.erro_op), 8'd1);
      chk("ill_d_reg_write", 8'(bus.reg_write), 8'd0);
      nx();
      chk("ill_next", 8'(bus.estado), 8'd0);
      chk("ill_erro_clear", 8'(bus.erro_op), 8'd0);

      // NOP
      fetch_decode(6'b000000);
      chk("nop_next", 8'(bus.estado), 8'd0);

      // HALT held for 20 cycles
      fetch_decode(6'b111111);
      for (int i = 0; i < 20; i++) begin
         chk("halt_halted", 8'(bus.halted), 8'd1);
         chk("halt_estado", 8'(bus.estado), 8'd5);
         chk("halt_mem_read", 8'(bus.mem_read), 8'd0);
         nx();
      end
      reset = 1'b1;
      #1;
      chk("halt_rst_halted", 8'(bus.halted), 8'd0);
      chk("halt_rst_estado", 8'(bus.estado), 8'd0);
      nx();
      reset = 1'b0;
      #1;
      chk("post_halt_mem_read", 8'(bus.mem_read), 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/unidade_controle_mc.md
Name: unidade_controle_mc

Overview:
- Multi-cycle control FSM for the MIPS-style datapath. It is the producer side of the ALU interface.
- Decodes the opcode held in the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives the 4-bit ALU operation code and consumes the ALU ZERO flag.
- Holds EXEC for a configurable number of cycles on MUL/DIV, so the combinational multiplier/divider meets timing.

Parameters:
MUL_CYCLES, 1, EXEC cycles for MUL (1..255)
DIV_CYCLES, 1, EXEC cycles for DIV (1..255)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; forces FETCH and clears all registered state
instrucao_op  in  6  opcode field IR[31:26]; stable from DECODE until next ir_write
zero  in  1  ALU ZERO flag
mem_ready  in  1  memory completes access this cycle
alu_op  out  4  operation code to ALU
alu_src_b  out  1  0 = register D2, 1 = sign-extended immediate
mem_read  out  1  memory read request
mem_write  out  1  memory write request
iord  out  1  memory address select: 0 = PC, 1 = ALU result
ir_write  out  1  load instruction register
pc_write  out  1  load PC
pc_src  out  2  00 = PC+1, 01 = branch target, 10 = jump target
reg_write  out  1  register file write
mem_to_reg  out  1  writeback data select: 0 = ALU, 1 = memory
resto_write  out  1  write DIV remainder register
erro_op  out  1  one-cycle pulse on illegal opcode
halted  out  1  processor stopped
estado  out  3  current state (debug)

Behaviour:
- States and encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5.
- Reset: state FETCH, cycle counter 0. All outputs are 0 while reset is high, including alu_op = 0000 and estado = 0.
- Outputs are decoded from state and instrucao_op. pc_write in EXEC for branches is additionally gated by zero (Mealy). All unlisted outputs are 0 in each state.
- Opcode map (opcode -> alu_op):
  - NOP 000000 -> none
  - ADD 000001 -> 0000; ADDI 000010 -> 0000
  - SUB 000011 -> 0001; SUBI 000100 -> 0001
  - MUL 000101 -> 0010; DIV 000110 -> 0011
  - NOT 000111 -> 0100; AND 001000 -> 0101; OR 001001 -> 0110; XOR 001010 -> 0111
  - SLT 001011 -> 1000; SGT 001100 -> 1001
  - SR 001101 -> 1100; SL 001110 -> 1101
  - BEQ 001111 -> 1010; BNEQ 010000 -> 1011
  - LW 010001 -> 0000; SW 010010 -> 0000
  - J 010011 -> none; HALT 111111 -> none
  - Every other opcode is illegal.
- FETCH: mem_read = 1, iord = 0. FSM waits while mem_ready = 0. On mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 00, next state DECODE.
- DECODE: 1 cycle.
  - HALT -> HALT.
  - NOP -> FETCH.
  - Illegal opcode -> erro_op = 1 this cycle, next state FETCH (executed as NOP).
  - All others -> EXEC, counter loaded with 0.
- EXEC: alu_op per opcode. alu_src_b = 1 for ADDI/SUBI/LW/SW, else 0.
  - MUL/DIV: FSM stays in EXEC until counter = MUL_CYCLES-1 (resp. DIV_CYCLES-1), incrementing each cycle; alu_op is held constant throughout. Value 1 means a single EXEC cycle.
  - BEQ/BNEQ: pc_src = 01, pc_write = zero, next state FETCH.
  - J: pc_write = 1, pc_src = 10, next state FETCH.
  - LW/SW: next state MEM.
  - All others: next state WB.
- MEM: iord = 1, alu_op = 0000, alu_src_b = 1 (address held).
  - LW: mem_read = 1; FSM waits for mem_ready, then WB.
  - SW: mem_write = 1; FSM waits for mem_ready, then FETCH.
  - Request stays asserted for every wait cycle.
- WB: reg_write = 1, mem_to_reg = 1 only for LW, resto_write = 1 only for DIV. alu_op is held at the EXEC value. Next state FETCH.
- HALT: halted = 1; no requests issued; exit only by reset.
- Reset mid-operation: asynchronous. Outputs drop to 0 within the same cycle, including any pending mem_read/mem_write. The interrupted access is abandoned.
- mem_ready outside FETCH/MEM is ignored.
- A zero value during non-branch EXEC is ignored.

Optional Feature:
- Macro: UNIDADE_CONTROLE_PASSO_EN.
- With it defined: adds input port passo (1 bit). FSM in FETCH issues no request (mem_read = 0) until it samples passo = 1. Fetch then proceeds normally (mem_read stays asserted through mem_ready waits). This gives single-instruction stepping.
- Without it: no passo port; FETCH issues its request immediately.

Test Plan:
- Reset, mem_ready = 1, opcode ADD 000001 -> estado 0,1,2,4,0. Cycle 1: ir_write = pc_write = 1. Cycle 3: alu_op = 0000, alu_src_b = 0. Cycle 4: reg_write = 1, mem_to_reg = 0.
- DIV_CYCLES = 4, opcode 000110 -> EXEC for exactly 4 cycles with alu_op = 0011 constant, then WB with reg_write = 1 and resto_write = 1.
- BEQ 001111 with zero = 1 -> EXEC pc_write = 1, pc_src = 01, alu_op = 1010. Repeat with zero = 0 -> pc_write = 0; next state FETCH in both cases.
- LW 010001, mem_ready low 3 cycles in MEM -> mem_read = 1, iord = 1 for 4 cycles, then WB with reg_write = 1, mem_to_reg = 1. Repeat with reset asserted in 2nd MEM cycle -> mem_read = 0 immediately, estado = 0.
- Opcode 100000 -> erro_op pulses 1 cycle in DECODE, no reg_write, back to FETCH.
- Opcode 111111 -> halted = 1 and estado = 5 held for 20 cycles with no mem_read, until reset.
